// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and defaults for the UART <-> data-memory bridge.
//   DefAddrW     : default memory address width
//   DefLoadBytes : default number of bytes captured per load (256x256 image)
//   state_e      : FSM state encoding; StIdle is all zeros so reset lands in idle
package uart_mem_bridge_pkg;

  localparam int unsigned DefAddrW     = 16;
  localparam int unsigned DefLoadBytes = 65536;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StRd     = 3'd2,
    StRdWait = 3'd3,
    StSend   = 3'd4,
    StAck    = 3'd5,
    StHold   = 3'd6
  } state_e;

endpackage

// File: rtl/uart_mem_bridge_rise_detect.sv
// Rising-edge detector: registers the input and pulses while din=1 and the
// registered copy is still 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : level input (UART rx_ready)
//   pulse      : high for the one cycle in which din has just risen
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// Bridge between the UART and the byte-wide data memory.
//   Load mode : each rising edge of rx_ready writes rx_data to the next address,
//               LOAD_BYTES bytes starting at address 0.
//   Dump mode : reads dump_len bytes from address 0 and hands each to the UART
//               transmitter, waiting for tx_busy to rise and fall per byte.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start_load, start_dump      : single-cycle start pulses (load wins if both)
//   dump_len                    : bytes to dump, sampled on start_dump
//   rx_ready, rx_data           : UART receive side
//   tx_busy, tx_data, tx_wr_en  : UART transmit side
//   mem_addr, mem_wdata, mem_we : memory write/read address port
//   mem_rdata                   : memory read data, one cycle after address
//   busy, done                  : status; done pulses once per finished transfer
// All outputs are registered.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned LOAD_BYTES = DefLoadBytes
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W:0]   dump_len,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = ADDR_W + 1;

  state_e state_q, state_d;
  logic [CntW-1:0]   count_q, count_d, count_inc;
  logic [CntW-1:0]   len_q, len_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_en_q, tx_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rx_rise;

  rise_detect u_rx_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx_ready),
    .pulse (rx_rise)
  );

  assign count_inc = count_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    tx_data_d   = tx_data_q;
    tx_wr_en_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_load) begin
          state_d = StLoad;
          count_d = '0;
        end else if (start_dump) begin
          len_d   = dump_len;
          count_d = '0;
          if (dump_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = StRd;
            mem_addr_d = '0;
          end
        end
      end
      StLoad: begin
        // Terminal check on the full-width counter, so 2^ADDR_W bytes still ends cleanly.
        if (count_q == CntW'(LOAD_BYTES)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (rx_rise) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q[ADDR_W-1:0];
          mem_wdata_d = rx_data;
          count_d     = count_inc;
        end
      end
      StRd:     state_d = StRdWait;
      StRdWait: begin
        // Read data for the address driven in StRd is valid in this cycle.
        state_d    = StSend;
        tx_data_d  = mem_rdata;
        tx_wr_en_d = 1'b1;
      end
      StSend:   state_d = StAck;
      StAck: begin
        if (tx_busy) state_d = StHold;
      end
      StHold: begin
        if (!tx_busy) begin
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d    = StRd;
            mem_addr_d = count_inc[ADDR_W-1:0];
          end
        end
      end
      default:  state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      len_q       <= '0;
      tx_data_q   <= '0;
      tx_wr_en_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      tx_data_q   <= tx_data_d;
      tx_wr_en_q  <= tx_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_wr_en  = tx_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed self-checking bench for uart_mem_bridge (ADDR_W=8, LOAD_BYTES=4).
module tb_uart_mem_bridge;

  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst_n;
  logic          start_load;
  logic          start_dump;
  logic [AW:0]   dump_len;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          done;

  uart_mem_bridge #(
    .ADDR_W     (AW),
    .LOAD_BYTES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_load (start_load),
    .start_dump (start_dump),
    .dump_len   (dump_len),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_wr_en   (tx_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous read, bench-side preload port, log of DUT writes.
  logic [7:0]    mem [256];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;
  logic [7:0]    wr_addr_log [$];
  logic [7:0]    wr_data_log [$];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
    mem_rdata <= mem[mem_addr];
  end

  // Transmitter model: busy from the cycle after tx_wr_en for 20 cycles.
  logic [7:0] tx_log [$];
  int         tx_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_hold <= 0;
    end else if (tx_wr_en) begin
      tx_log.push_back(tx_data);
      tx_busy <= 1'b1;
      tx_hold <= 19;
    end else if (tx_busy) begin
      if (tx_hold == 0) tx_busy <= 1'b0;
      else              tx_hold <= tx_hold - 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    step();
    pre_we = 1'b0;
  endtask

  // One received byte: edge in cycle t, write seen in t+1, done in t+2 for the last.
  task automatic rx_byte(input logic [7:0] b, input int idx, input int hold, input bit last);
    rx_data = b; rx_ready = 1'b1;
    step();
    rx_data = ~b;
    check_eq("load_we", 32'(mem_we), 32'd1);
    check_eq("load_addr", 32'(mem_addr), 32'(idx));
    check_eq("load_wdata", 32'(mem_wdata), 32'(b));
    step();
    check_eq("load_we_once", 32'(mem_we), 32'd0);
    check_eq("load_done", 32'(done), 32'(last));
    check_eq("load_busy", 32'(busy), 32'(!last));
    repeat (hold) step();
    rx_ready = 1'b0;
    step();
  endtask

  logic [7:0] exp_v [3];
  int wr_cyc [3];
  int pulses, bad, fall_cyc, done_cyc;
  bit timed_out;

  // Starts a dump and tracks it cycle by cycle (cycle 1 = first cycle after start).
  task automatic run_dump(input int len, input int stop_after);
    logic prev_busy;
    pulses = 0; bad = 0; fall_cyc = 0; done_cyc = 0; timed_out = 1'b1;
    prev_busy = 1'b0;
    dump_len = (AW+1)'(len); start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    check_eq("dump_busy_rise", 32'(busy), 32'd1);
    for (int c = 1; c <= 200; c++) begin
      if (tx_wr_en) begin
        if (pulses < 3) wr_cyc[pulses] = c;
        pulses++;
        if (stop_after != 0 && pulses == stop_after) begin
          timed_out = 1'b0;
          return;
        end
      end
      if (pulses > 0 && pulses <= 3 && tx_data !== exp_v[pulses-1]) bad++;
      if (prev_busy && !tx_busy) fall_cyc = c;
      if (done) begin
        done_cyc  = c;
        timed_out = 1'b0;
        break;
      end
      prev_busy = tx_busy;
      step();
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start_load = 1'b0; start_dump = 1'b0; dump_len = '0;
    rx_ready = 1'b0; rx_data = 8'h00; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset with rx_ready toggling.
    for (int i = 0; i < 6; i++) begin
      rx_ready = ~rx_ready;
      step();
    end
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rx_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check_eq("rst_no_writes", 32'(wr_addr_log.size()), 32'd0);

    // Load of 4 bytes; second byte holds rx_ready high for 10 cycles.
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    check_eq("load_busy_rise", 32'(busy), 32'd1);
    rx_byte(8'hA5, 0, 0, 1'b0);
    rx_byte(8'h3C, 1, 10, 1'b0);
    rx_byte(8'hFF, 2, 0, 1'b0);
    rx_byte(8'h00, 3, 0, 1'b1);
    check_eq("load_done_pulse", 32'(done), 32'd0);
    check_eq("load_nwrites", 32'(wr_addr_log.size()), 32'd4);
    if (wr_data_log.size() == 4) begin
      check_eq("load_log0", 32'(wr_data_log[0]), 32'hA5);
      check_eq("load_log1", 32'(wr_data_log[1]), 32'h3C);
      check_eq("load_log2", 32'(wr_data_log[2]), 32'hFF);
      check_eq("load_log3", 32'(wr_data_log[3]), 32'h00);
    end

    // Dump of 3 bytes against the 20-cycle transmitter.
    preload(8'd0, 8'h11);
    preload(8'd1, 8'h22);
    preload(8'd2, 8'h33);
    step();
    exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33;
    base = tx_log.size();
    run_dump(3, 0);
    check_eq("dump_timeout", 32'(timed_out), 32'd0);
    check_eq("dump_pulses", 32'(pulses), 32'd3);
    check_eq("dump_wr0_cyc", 32'(wr_cyc[0]), 32'd3);
    check_eq("dump_wr1_cyc", 32'(wr_cyc[1]), 32'd27);
    check_eq("dump_wr2_cyc", 32'(wr_cyc[2]), 32'd51);
    check_eq("dump_last_fall", 32'(fall_cyc), 32'd72);
    check_eq("dump_done_cyc", 32'(done_cyc), 32'd73);
    check_eq("dump_tx_stable", 32'(bad), 32'd0);
    check_eq("dump_busy_end", 32'(busy), 32'd0);
    check_eq("dump_nlog", 32'(tx_log.size() - base), 32'd3);
    if (tx_log.size() == base + 3) begin
      check_eq("dump_tx0", 32'(tx_log[base]), 32'h11);
      check_eq("dump_tx1", 32'(tx_log[base+1]), 32'h22);
      check_eq("dump_tx2", 32'(tx_log[base+2]), 32'h33);
    end
    step();
    check_eq("dump_done_pulse", 32'(done), 32'd0);

    // Zero-length dump: done next cycle, no transmit.
    base = tx_log.size();
    dump_len = '0; start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_busy", 32'(busy), 32'd0);
    repeat (5) step();
    check_eq("zero_no_tx", 32'(tx_log.size() - base), 32'd0);

    // Both starts together: load wins; a start_dump during the load is ignored.
    base = tx_log.size();
    dump_len = (AW+1)'(3); start_load = 1'b1; start_dump = 1'b1;
    step();
    start_load = 1'b0; start_dump = 1'b0;
    check_eq("arb_busy", 32'(busy), 32'd1);
    rx_byte(8'h01, 0, 0, 1'b0);
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    rx_byte(8'h02, 1, 0, 1'b0);
    rx_byte(8'h03, 2, 0, 1'b0);
    rx_byte(8'h04, 3, 0, 1'b1);
    repeat (5) step();
    check_eq("arb_nwrites", 32'(wr_addr_log.size()), 32'd8);
    check_eq("arb_no_tx", 32'(tx_log.size() - base), 32'd0);
    check_eq("arb_idle", 32'(busy), 32'd0);

    // Reset in the cycle of the second transmit strobe, then restart.
    exp_v[0] = 8'h01; exp_v[1] = 8'h02; exp_v[2] = 8'h03;
    run_dump(3, 2);
    check_eq("mid_reached_wr2", 32'(timed_out), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_tx_wr_en", 32'(tx_wr_en), 32'd0);
    check_eq("mid_tx_data", 32'(tx_data), 32'd0);
    check_eq("mid_mem_addr", 32'(mem_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    base = tx_log.size();
    run_dump(2, 0);
    check_eq("restart_timeout", 32'(timed_out), 32'd0);
    check_eq("restart_pulses", 32'(pulses), 32'd2);
    check_eq("restart_done_cyc", 32'(done_cyc), 32'd49);
    check_eq("restart_nlog", 32'(tx_log.size() - base), 32'd2);
    if (tx_log.size() == base + 2) begin
      check_eq("restart_tx0", 32'(tx_log[base]), 32'h01);
      check_eq("restart_tx1", 32'(tx_log[base+1]), 32'h02);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
